// File: rtl/hw5_alu_ctrl.sv
// Command sequencer for the external 16-bit ALU: one-shot ADD/AND/NOT plus a
// shift-add MUL that reuses the ALU adder once per multiplier bit.
module hw5_alu_ctrl #(
  parameter bit MUL_EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        busy,
  output logic [1:0]  alu_control,
  output logic [15:0] aluin1,
  output logic [15:0] aluin2,
  input  logic [15:0] aluout,
  input  logic        alu_carry
);

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned STEP_W  = 4;
  localparam logic [1:0]  OP_ADD  = 2'd0;
  localparam logic [1:0]  OP_MUL  = 2'd3;
  localparam logic [1:0]  ALU_ZERO = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL_STEP, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_op, w_op_nxt;
  logic [WIDTH-1:0]   r_a, w_a_nxt;
  logic [WIDTH-1:0]   r_b, w_b_nxt;
  logic [WIDTH-1:0]   r_acc, w_acc_nxt;
  logic               r_sticky, w_sticky_nxt;
  logic [STEP_W-1:0]  r_step, w_step_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [WIDTH-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic               r_rsp_carry, w_rsp_carry_nxt;
  logic               r_cmd_ready, r_busy;
  logic [1:0]         r_alu_ctrl, w_alu_ctrl_nxt;
  logic [WIDTH-1:0]   r_alu_in1, w_alu_in1_nxt;
  logic [WIDTH-1:0]   r_alu_in2, w_alu_in2_nxt;

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_acc_nxt       = r_acc;
    w_sticky_nxt    = r_sticky;
    w_step_nxt      = r_step;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_carry_nxt = r_rsp_carry;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt     = cmd_op;
          w_a_nxt      = cmd_a;
          w_b_nxt      = cmd_b;
          w_acc_nxt    = '0;
          w_sticky_nxt = 1'b0;
          w_step_nxt   = '0;
          w_state_nxt  = (cmd_op == OP_MUL) ? S_MUL_STEP : S_EXEC;
        end
      end
      S_EXEC: begin
        w_rsp_data_nxt  = aluout;
        w_rsp_carry_nxt = (r_op == OP_ADD) & alu_carry;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      S_MUL_STEP: begin
        if (r_b[0]) begin
          w_acc_nxt    = aluout;
          w_sticky_nxt = r_sticky | alu_carry;
        end
        // A multiplicand bit shifting out while higher multiplier bits remain means overflow
        w_sticky_nxt = w_sticky_nxt | (r_a[WIDTH-1] & (|r_b[WIDTH-1:1]));
        w_a_nxt      = r_a << 1;
        w_b_nxt      = r_b >> 1;
        w_step_nxt   = r_step + STEP_W'(1);
        if ((r_step == STEP_W'(WIDTH - 1)) || (MUL_EARLY_EXIT && (w_b_nxt == '0))) begin
          w_rsp_data_nxt  = w_acc_nxt;
          w_rsp_carry_nxt = w_sticky_nxt;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // ALU drive for the cycle that follows this edge
    w_alu_ctrl_nxt = ALU_ZERO;
    w_alu_in1_nxt  = '0;
    w_alu_in2_nxt  = '0;
    if (w_state_nxt == S_EXEC) begin
      w_alu_ctrl_nxt = w_op_nxt;
      w_alu_in1_nxt  = w_a_nxt;
      w_alu_in2_nxt  = w_b_nxt;
    end else if ((w_state_nxt == S_MUL_STEP) && w_b_nxt[0]) begin
      w_alu_ctrl_nxt = OP_ADD;
      w_alu_in1_nxt  = w_acc_nxt;
      w_alu_in2_nxt  = w_a_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_sticky    <= 1'b0;
      r_step      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_carry <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_alu_ctrl  <= ALU_ZERO;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_acc       <= w_acc_nxt;
      r_sticky    <= w_sticky_nxt;
      r_step      <= w_step_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_carry <= w_rsp_carry_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_alu_ctrl  <= w_alu_ctrl_nxt;
      r_alu_in1   <= w_alu_in1_nxt;
      r_alu_in2   <= w_alu_in2_nxt;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_carry   = r_rsp_carry;
  assign alu_control = r_alu_ctrl;
  assign aluin1      = r_alu_in1;
  assign aluin2      = r_alu_in2;

endmodule

// File: tb/tb_hw5_alu_ctrl.sv
// Directed and seeded-random bench for hw5_alu_ctrl; instance 0 uses MUL early
// exit, instance 1 always runs 16 MUL steps. Each instance has its own ALU model.
`timescale 1ns/1ps
module tb_hw5_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [1:0]  cmd_op    [2];
  logic [15:0] cmd_a     [2];
  logic [15:0] cmd_b     [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_data  [2];
  logic        rsp_carry [2];
  logic        busy      [2];
  logic [1:0]  alu_control [2];
  logic [15:0] aluin1    [2];
  logic [15:0] aluin2    [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] aluout;
    logic        alu_carry;

    // Reference 16-bit ALU: 0=ADD, 1=AND, 2=NOT a, 3=zero
    always_comb begin
      aluout    = '0;
      alu_carry = 1'b0;
      case (alu_control[g])
        2'd0:    {alu_carry, aluout} = 17'(aluin1[g]) + 17'(aluin2[g]);
        2'd1:    aluout = aluin1[g] & aluin2[g];
        2'd2:    aluout = ~aluin1[g];
        default: aluout = '0;
      endcase
    end

    hw5_alu_ctrl #(.MUL_EARLY_EXIT(g == 0)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_op     (cmd_op[g]),
      .cmd_a      (cmd_a[g]),
      .cmd_b      (cmd_b[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_data   (rsp_data[g]),
      .rsp_carry  (rsp_carry[g]),
      .busy       (busy[g]),
      .alu_control(alu_control[g]),
      .aluin1     (aluin1[g]),
      .aluin2     (aluin2[g]),
      .aluout     (aluout),
      .alu_carry  (alu_carry)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present a command at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int i, input string tag, input logic [1:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    while (!cmd_ready[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, 32'(cmd_ready[i]), 32'd1);
    cmd_op[i]    = op;
    cmd_a[i]     = a;
    cmd_b[i]     = b;
    cmd_valid[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[i] = 1'b0;
    cmd_a[i]     = 16'(~a);
    cmd_b[i]     = 16'(~b);
  endtask

  // Edges counted from (and including) the accept edge until rsp_valid is seen.
  task automatic await_rsp(input int i, input string tag, input logic [15:0] ed,
                           input logic ec, input int edges);
    int n = 1;
    while (!rsp_valid[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_lat"}, 32'(n), 32'(edges));
    check_eq({tag, "_data"}, 32'(rsp_data[i]), 32'(ed));
    check_eq({tag, "_carry"}, 32'(rsp_carry[i]), 32'(ec));
  endtask

  task automatic consume(input int i, input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
  endtask

  task automatic run_op(input int i, input string tag, input logic [1:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ed, input logic ec, input int edges, input int hold);
    issue(i, tag, op, a, b);
    await_rsp(i, tag, ed, ec, edges);
    consume(i, hold);
  endtask

  function automatic int mul_steps(input logic [15:0] b, input bit early);
    if (!early) return 16;
    for (int j = 15; j >= 0; j--)
      if (b[j]) return j + 1;
    return 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [15:0] a, b, ed;
    logic        ec;
    logic [31:0] p;
    int          edges;
    logic        seen;

    for (int i = 0; i < 2; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_op[i]    = '0;
      cmd_a[i]     = '0;
      cmd_b[i]     = '0;
      rsp_ready[i] = 1'b0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_cmd_ready", 32'(cmd_ready[i]), 32'd1);
      check_eq("rst_busy", 32'(busy[i]), 32'd0);
      check_eq("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check_eq("rst_alu_ctrl", 32'(alu_control[i]), 32'd3);
      check_eq("rst_aluin1", 32'(aluin1[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // One-shot ops: accept edge + EXEC edge
    run_op(0, "add_carry", 2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 2, 0);
    run_op(0, "and", 2'd1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 2, 1);
    run_op(0, "not", 2'd2, 16'h1234, 16'h5555, 16'hEDCB, 1'b0, 2, 0);
    check_eq("idle_alu_ctrl", 32'(alu_control[0]), 32'd3);
    check_eq("idle_aluin2", 32'(aluin2[0]), 32'd0);

    // MUL: accept edge + one edge per step
    run_op(0, "mul_a", 2'd3, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 8, 0);
    run_op(0, "mul_b", 2'd3, 16'h0100, 16'h0100, 16'h0000, 1'b1, 10, 0);
    run_op(0, "mul_c", 2'd3, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 17, 0);
    run_op(0, "mul_z", 2'd3, 16'h1234, 16'h0000, 16'h0000, 1'b0, 2, 0);
    run_op(1, "mul_a_full", 2'd3, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 17, 0);
    run_op(1, "mul_z_full", 2'd3, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17, 0);

    // Backpressure with a pending command
    issue(0, "bp", 2'd0, 16'h1111, 16'h2222);
    await_rsp(0, "bp", 16'h3333, 1'b0, 2);
    cmd_op[0] = 2'd1; cmd_a[0] = 16'hFFFF; cmd_b[0] = 16'h00FF; cmd_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("bp_hold_data", 32'(rsp_data[0]), 32'h3333);
      check_eq("bp_hold_ready", 32'(cmd_ready[0]), 32'd0);
      check_eq("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    check_eq("bp_rel_valid", 32'(rsp_valid[0]), 32'd0);
    check_eq("bp_rel_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    check_eq("bp_next_busy", 32'(busy[0]), 32'd1);
    await_rsp(0, "bp_next", 16'h00FF, 1'b0, 2);
    consume(0, 0);

    // Reset during MUL step 4 drops the operation
    issue(0, "rst_mul", 2'd3, 16'hFFFF, 16'hFFFF);
    repeat (3) @(negedge clk);
    check_eq("rst_mul_ctrl", 32'(alu_control[0]), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mul_ready", 32'(cmd_ready[0]), 32'd1);
    check_eq("rst_mul_busy", 32'(busy[0]), 32'd0);
    check_eq("rst_mul_data", 32'(rsp_data[0]), 32'd0);
    check_eq("rst_mul_alu", 32'(alu_control[0]), 32'd3);
    check_eq("rst_mul_in1", 32'(aluin1[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | rsp_valid[0];
    end
    check_eq("rst_mul_norsp", 32'(seen), 32'd0);
    run_op(0, "post_rst_add", 2'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 2, 0);

    // Seeded random ops with random backpressure on both variants
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 30; k++) begin
        op = 2'($urandom_range(0, 3));
        a  = 16'($urandom);
        b  = 16'($urandom);
        if (k % 3 == 0) b = b & 16'h00FF;
        p = 32'(a) * 32'(b);
        case (op)
          2'd0:    {ec, ed} = 17'(a) + 17'(b);
          2'd1:    begin ed = a & b; ec = 1'b0; end
          2'd2:    begin ed = ~a;    ec = 1'b0; end
          default: begin ed = p[15:0]; ec = (p[31:16] != 16'd0); end
        endcase
        edges = (op == 2'd3) ? 1 + mul_steps(b, i == 0) : 2;
        run_op(i, "rand", op, a, b, ed, ec, edges, $urandom_range(0, 3));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
